mulmac_periph: RTL and testbench

Parametrised memory-mapped multiply/multiply-accumulate peripheral on the openMSP430 peripheral bus, the successor to the single-cycle 32x32 multiplier. It has the following features:
- Operand width is configurable in 16-bit words.
- Signed and unsigned modes.
- Optional accumulation into the 2N-bit result register.
- A multi-cycle shift-add datapath with BUSY/DONE status and an interrupt request.

It sits alongside the other peripherals on `per_addr`/`per_din`/`per_dout`.

---
 rtl/mulmac_periph_if.sv | 11 +
 rtl/mulmac_periph.sv | 146 ++++++++++++++
 tb/tb_mulmac_periph.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mulmac_periph_if.sv
// mulmac_periph_if: openMSP430 peripheral bus bundle for mulmac_periph
interface mulmac_periph_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        irq;
  modport master (output per_addr, per_din, per_en, per_we, input per_dout, irq);
  modport slave (input per_addr, per_din, per_en, per_we, output per_dout, irq);
endinterface

// File: rtl/mulmac_periph.sv
// mulmac_periph: memory-mapped shift-add multiply/multiply-accumulate peripheral
module mulmac_periph #(
  parameter logic [13:0] BASE_ADDR = 14'h0A0,
  parameter int WORDS = 2
) (
  input logic mclk,
  input logic puc_rst,
  mulmac_periph_if.slave bus
);
  localparam int N = 16 * WORDS;
  localparam int CW = $clog2(N);
  localparam logic [13:0] CTL_OFF = 14'(4 * WORDS);
  localparam logic [13:0] STAT_OFF = 14'(4 * WORDS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, mplier_q, mplier_d, a_abs, b_abs;
  logic [2*N-1:0] res_q, res_d, mcand_q, mcand_d, prod_q, prod_d, fix_p;
  logic [2*N:0] fix_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed_q, signed_d, acc_q, acc_d, ie_q, ie_d, done_q, done_d;
  logic ovf_q, ovf_d, irq_q, irq_d, neg_q, neg_d;
  logic [13:0] off;
  logic [15:0] rdata;
  logic busy, wr, rd, start, fix_ovf;
  assign off = bus.per_addr - BASE_ADDR;
  assign busy = state_q != IDLE;
  assign wr = bus.per_en && bus.per_we == 2'b11 && off <= STAT_OFF;
  assign rd = bus.per_en && bus.per_we == 2'b00 && off <= STAT_OFF;
  assign start = wr && !busy && off == CTL_OFF && bus.per_din[0];
  assign a_abs = (signed_q && a_q[N-1]) ? -a_q : a_q;
  assign b_abs = (signed_q && b_q[N-1]) ? -b_q : b_q;
  assign fix_p = neg_q ? -prod_q : prod_q;
  assign fix_sum = {1'b0, res_q} + {1'b0, fix_p};
  // signed overflow: operands agree in sign but the sum does not
  assign fix_ovf = signed_q ? (res_q[2*N-1] == fix_p[2*N-1]) && (fix_sum[2*N-1] != res_q[2*N-1])
                            : fix_sum[2*N];
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    signed_d = signed_q;
    acc_d = acc_q;
    ie_d = ie_q;
    done_d = done_q;
    ovf_d = ovf_q;
    irq_d = done_q & ie_q;
    if (wr && !busy) begin
      for (int i = 0; i < WORDS; i++) begin
        if (off == 14'(i)) a_d[16*i +: 16] = bus.per_din;
        if (off == 14'(WORDS + i)) b_d[16*i +: 16] = bus.per_din;
      end
      for (int i = 0; i < 2 * WORDS; i++)
        if (off == 14'(2 * WORDS + i)) res_d[16*i +: 16] = bus.per_din;
    end
    if (wr && off == CTL_OFF) begin
      ie_d = bus.per_din[3];
      signed_d = busy ? signed_q : bus.per_din[1];
      acc_d = busy ? acc_q : bus.per_din[2];
    end
    if (wr && off == STAT_OFF) begin
      done_d = bus.per_din[1] ? 1'b0 : done_q;
      ovf_d = bus.per_din[2] ? 1'b0 : ovf_q;
    end
    if (start) done_d = 1'b0;
    if (state_q == FIX) begin
      res_d = acc_q ? fix_sum[2*N-1:0] : fix_p;
      done_d = 1'b1;
      ovf_d = ovf_q | (acc_q & fix_ovf);
    end
  end
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    prod_d = prod_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: begin
        mcand_d = {{N{1'b0}}, a_abs};
        mplier_d = b_abs;
        prod_d = '0;
        cnt_d = CW'(N - 1);
        neg_d = signed_q & (a_q[N-1] ^ b_q[N-1]);
        state_d = RUN;
      end
      RUN: begin
        prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? FIX : RUN;
      end
      FIX: state_d = IDLE;
    endcase
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (off == 14'(i)) rdata = a_q[16*i +: 16];
      if (off == 14'(WORDS + i)) rdata = b_q[16*i +: 16];
    end
    for (int i = 0; i < 2 * WORDS; i++)
      if (off == 14'(2 * WORDS + i)) rdata = res_q[16*i +: 16];
    if (off == CTL_OFF) rdata = {12'b0, ie_q, acc_q, signed_q, 1'b0};
    if (off == STAT_OFF) rdata = {13'b0, ovf_q, done_q, busy};
  end
  assign bus.per_dout = rd ? rdata : 16'h0;
  assign bus.irq = irq_q;
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      prod_q <= '0;
      cnt_q <= '0;
      signed_q <= 1'b0;
      acc_q <= 1'b0;
      ie_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      signed_q <= signed_d;
      acc_q <= acc_d;
      ie_q <= ie_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      neg_q <= neg_d;
    end
  end
endmodule

// File: tb/tb_mulmac_periph.sv
// tb_mulmac_periph: scoreboard bench for W=2 and W=4 builds sharing one bus
module tb_mulmac_periph;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [13:0] addr = '0;
  logic [15:0] din = '0;
  logic en = 1'b0;
  logic [1:0] we = 2'b00;
  int checks = 0;
  int errors = 0;
  typedef struct {int w; logic [127:0] res; logic ovf;} exp_t;
  exp_t sb[$];
  logic [127:0] res_m [2];
  logic ovf_m [2];
  logic [15:0] dout;
  always #5 clk = ~clk;
  mulmac_periph_if bus2();
  mulmac_periph_if bus4();
  assign bus2.per_addr = addr;
  assign bus2.per_din = din;
  assign bus2.per_en = en;
  assign bus2.per_we = we;
  assign bus4.per_addr = addr;
  assign bus4.per_din = din;
  assign bus4.per_en = en;
  assign bus4.per_we = we;
  assign dout = bus2.per_dout | bus4.per_dout;
  mulmac_periph #(.BASE_ADDR(14'h0A0), .WORDS(2)) dut2 (.mclk(clk), .puc_rst(rst), .bus(bus2));
  mulmac_periph #(.BASE_ADDR(14'h100), .WORDS(4)) dut4 (.mclk(clk), .puc_rst(rst), .bus(bus4));
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [13:0] base_of(input int w);
    return (w == 2) ? 14'h0A0 : 14'h100;
  endfunction
  function automatic int ix(input int w);
    return (w == 4) ? 1 : 0;
  endfunction
  function automatic logic [128:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic [127:0] res, input logic sgn, input logic acc);
    logic [263:0] one, mn, m2, ae, be, p, rs, s;
    logic signed [263:0] ss, lim;
    logic ov;
    int n;
    n = 16 * w;
    one = 264'd1;
    mn = (one << n) - one;
    m2 = (one << (2 * n)) - one;
    ae = {200'b0, a} & mn;
    be = {200'b0, b} & mn;
    if (sgn && ae[n-1]) ae = ae | ~mn;
    if (sgn && be[n-1]) be = be | ~mn;
    p = ae * be;
    rs = {136'b0, res} & m2;
    if (sgn && rs[2*n-1]) rs = rs | ~m2;
    s = rs + p;
    ss = s;
    lim = one << (2 * n - 1);
    ov = sgn ? (ss >= lim || ss < -lim) : (s > m2);
    return acc ? {ov, s[127:0] & m2[127:0]} : {1'b0, p[127:0] & m2[127:0]};
  endfunction
  task automatic wrb(input logic [13:0] a, input logic [15:0] d, input logic [1:0] bwe);
    @(negedge clk);
    addr = a;
    din = d;
    we = bwe;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    we = 2'b00;
  endtask
  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    wrb(a, d, 2'b11);
  endtask
  task automatic rd(input logic [13:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a;
    we = 2'b00;
    en = 1'b1;
    #1;
    d = dout;
    en = 1'b0;
  endtask
  task automatic load_ab(input int w, input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < w; i++) begin
      wr(base_of(w) + 14'(i), a[16*i +: 16]);
      wr(base_of(w) + 14'(w + i), b[16*i +: 16]);
    end
  endtask
  task automatic launch(input int w, input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctl);
    logic [128:0] r;
    exp_t e;
    r = model(w, a, b, res_m[ix(w)], ctl[1], ctl[2]);
    e.w = w;
    e.res = r[127:0];
    e.ovf = ovf_m[ix(w)] | r[128];
    sb.push_back(e);
    res_m[ix(w)] = e.res;
    ovf_m[ix(w)] = e.ovf;
    wr(base_of(w) + 14'(4 * w), {12'b0, ctl});
  endtask
  task automatic start_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctl);
    load_ab(w, a, b);
    launch(w, a, b, ctl);
  endtask
  task automatic preload(input int w, input logic [127:0] v);
    for (int i = 0; i < 2 * w; i++) wr(base_of(w) + 14'(2 * w + i), v[16*i +: 16]);
    res_m[ix(w)] = v;
  endtask
  task automatic clear_stat(input int w);
    wr(base_of(w) + 14'(4 * w + 1), 16'h0006);
    ovf_m[ix(w)] = 1'b0;
  endtask
  task automatic finish_op(input int w, input int exp_busy, output logic [1:0] irqs);
    logic [15:0] st, wd;
    logic [127:0] got;
    exp_t e;
    int n;
    n = 0;
    st = 16'h0001;
    for (int c = 0; c < 300 && st[0]; c++) begin
      rd(base_of(w) + 14'(4 * w + 1), st);
      if (st[0]) n++;
    end
    irqs[0] = (w == 2) ? bus2.irq : bus4.irq;
    checks++;
    if (st[0] !== 1'b0 || st[1] !== 1'b1) begin
      errors++;
      $display("FAIL done_w%0d: stat=%h, required busy=0 done=1", w, st);
    end
    if (exp_busy > 0) begin
      checks++;
      if (n !== exp_busy) begin
        errors++;
        $display("FAIL busy_cycles_w%0d: got %0d, expected %0d", w, n, exp_busy);
      end
    end
    got = '0;
    for (int i = 0; i < 2 * w; i++) begin
      rd(base_of(w) + 14'(2 * w + i), wd);
      got[16*i +: 16] = wd;
      if (i == 0) irqs[1] = (w == 2) ? bus2.irq : bus4.irq;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_w%0d: result %h with no expected entry", w, got);
    end else begin
      e = sb.pop_front();
      if (got !== e.res) begin
        errors++;
        $display("FAIL res_w%0d: got %h, expected %h", w, got, e.res);
      end
      checks++;
      if (st[2] !== e.ovf) begin
        errors++;
        $display("FAIL ovf_w%0d: got %b, expected %b", w, st[2], e.ovf);
      end
    end
  endtask
  task automatic check_zero_state(input string tag);
    logic [15:0] wd, ctl, st;
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      rd(14'h0A4 + 14'(i), wd);
      r[16*i +: 16] = wd;
    end
    rd(14'h0A8, ctl);
    rd(14'h0A9, st);
    checks++;
    if (r !== 64'h0) begin errors++; $display("FAIL %s_res: got %h, expected 0", tag, r); end
    checks++;
    if (ctl !== 16'h0) begin errors++; $display("FAIL %s_ctl: got %h, expected 0", tag, ctl); end
    checks++;
    if (st !== 16'h0) begin errors++; $display("FAIL %s_stat: got %h, expected 0", tag, st); end
    checks++;
    if (bus2.irq !== 1'b0 || bus4.irq !== 1'b0) begin
      errors++;
      $display("FAIL %s_irq: got %b%b, expected 00", tag, bus2.irq, bus4.irq);
    end
  endtask
  task automatic test_reset;
    logic [15:0] wd;
    res_m[0] = '0; res_m[1] = '0; ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_zero_state("reset");
    rd(14'h111, wd);
    checks++;
    if (wd !== 16'h0) begin errors++; $display("FAIL reset_stat_w4: got %h, expected 0", wd); end
    rd(14'h050, wd);
    checks++;
    if (wd !== 16'h0) begin errors++; $display("FAIL unselected_read: got %h, expected 0", wd); end
  endtask
  task automatic test_unsigned;
    logic [1:0] irqs;
    logic [15:0] wd;
    start_op(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'b0001);
    finish_op(2, 34, irqs);
    rd(14'h0A8, wd);
    checks++;
    if (wd !== 16'h0) begin errors++; $display("FAIL ctl_start_reads0: got %h, expected 0", wd); end
  endtask
  task automatic test_signed;
    logic [1:0] irqs;
    start_op(2, 64'hFFFF_FFFF, 64'h2, 4'b0011);
    finish_op(2, 34, irqs);
    start_op(2, 64'h8000_0000, 64'h8000_0000, 4'b0011);
    finish_op(2, 34, irqs);
  endtask
  task automatic test_random;
    logic [1:0] irqs;
    logic [63:0] a, b;
    logic [3:0] ctl;
    for (int k = 0; k < 6; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      ctl = {1'b0, 1'(k >> 1), 1'(k), 1'b1};
      start_op(2, a, b, ctl);
      finish_op(2, 34, irqs);
    end
  endtask
  task automatic test_accumulate;
    logic [1:0] irqs;
    clear_stat(2);
    preload(2, 128'hFFFF_FFFF_FFFF_FFFF);
    start_op(2, 64'h1, 64'h1, 4'b0101);
    finish_op(2, 34, irqs);
    start_op(2, 64'h2, 64'h3, 4'b0001);
    finish_op(2, 34, irqs);
    clear_stat(2);
    preload(2, 128'hFFFF_FFFF_FFFF_FFFF);
    start_op(2, 64'h1, 64'h1, 4'b0111);
    finish_op(2, 34, irqs);
  endtask
  task automatic test_busy;
    logic [1:0] irqs;
    logic [127:0] prev;
    logic [15:0] wd, st;
    prev = res_m[0];
    start_op(2, 64'h3, 64'h5, 4'b0001);
    repeat (5) @(posedge clk);
    rd(14'h0A4, wd);
    rd(14'h0A9, st);
    checks++;
    if (wd !== prev[15:0]) begin errors++; $display("FAIL res_during_busy: got %h, expected %h", wd, prev[15:0]); end
    checks++;
    if (st[0] !== 1'b1) begin errors++; $display("FAIL busy_flag: got %b, expected 1", st[0]); end
    wr(14'h0A0, 16'hFFFF);
    wr(14'h0A4, 16'h1234);
    wr(14'h0A8, 16'h0007);
    finish_op(2, -1, irqs);
    rd(14'h0A8, wd);
    checks++;
    if (wd !== 16'h0) begin errors++; $display("FAIL ctl_after_busy_write: got %h, expected 0", wd); end
  endtask
  task automatic test_byte_write;
    logic [1:0] irqs;
    load_ab(2, 64'h2, 64'h3);
    wrb(14'h0A0, 16'h00FF, 2'b01);
    wrb(14'h0A1, 16'hFF00, 2'b10);
    launch(2, 64'h2, 64'h3, 4'b0001);
    finish_op(2, 34, irqs);
  endtask
  task automatic test_irq;
    logic [1:0] irqs;
    start_op(2, 64'h7, 64'h9, 4'b1001);
    finish_op(2, 34, irqs);
    checks++;
    if (irqs !== 2'b10) begin errors++; $display("FAIL irq_rise: got %b, expected 10 (after,at_done)", irqs); end
    wr(14'h0A9, 16'h0002);
    @(negedge clk);
    checks++;
    if (bus2.irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b, expected 1", bus2.irq); end
    @(negedge clk);
    checks++;
    if (bus2.irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b, expected 0", bus2.irq); end
  endtask
  task automatic test_back_to_back;
    logic [1:0] irqs;
    exp_t e;
    preload(2, 128'h1111);
    start_op(2, 64'h1234, 64'h10, 4'b0101);
    repeat (34) @(posedge clk);
    launch(2, 64'h1234, 64'h10, 4'b0101);
    e = sb.pop_front();
    finish_op(2, 34, irqs);
  endtask
  task automatic test_abort;
    logic [1:0] irqs;
    exp_t e;
    start_op(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'b1001);
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    e = sb.pop_back();
    res_m[0] = '0; res_m[1] = '0; ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
    check_zero_state("abort");
    start_op(2, 64'h1234_5678, 64'h9ABC_DEF0, 4'b0001);
    finish_op(2, 34, irqs);
  endtask
  task automatic test_w4;
    logic [1:0] irqs;
    start_op(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001);
    finish_op(4, 66, irqs);
    start_op(4, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0011);
    finish_op(4, 66, irqs);
  endtask
  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_random;
    test_accumulate;
    test_busy;
    test_byte_write;
    test_irq;
    test_back_to_back;
    test_abort;
    test_w4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
